// File: rtl/uart_cmd_rx.sv
// uart_cmd_rx: buffers bytes from the UART receiver in a small FIFO and
// parses line-oriented ASCII commands ("I/D/S <hex>", "P") into an opcode
// plus a hex argument presented on a valid/ready handshake.
// Optional feature macro: UART_CMD_RX_ECHO_EN adds a registered echo port
// carrying every byte the parser consumes; the parser stalls on it.
module uart_cmd_rx #(
    parameter int DATA_W     = 16,
    parameter int FIFO_DEPTH = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_rx_valid,
    input  logic [7:0]        i_rx_data,
    output logic              o_cmd_valid,
    input  logic              i_cmd_ready,
    output logic [1:0]        o_cmd_op,
    output logic [DATA_W-1:0] o_cmd_data,
    output logic              o_err,
    output logic              o_ovf
`ifdef UART_CMD_RX_ECHO_EN
    ,
    output logic              o_echo_valid,
    output logic [7:0]        o_echo_data,
    input  logic              i_echo_ready
`endif
);

    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int MAXD = DATA_W / 4;
    localparam int CW   = $clog2(MAXD + 1);

    localparam logic [AW:0]   DEPTH_C = (AW + 1)'(FIFO_DEPTH);
    localparam logic [AW:0]   PTR_ONE = (AW + 1)'(1);
    localparam logic [CW-1:0] MAXD_C  = CW'(MAXD);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_ARG  = 3'd1;
    localparam logic [2:0] S_EOL  = 3'd2;
    localparam logic [2:0] S_OUT  = 3'd3;
    localparam logic [2:0] S_ERR  = 3'd4;

    localparam logic [1:0] OP_INS = 2'd0;
    localparam logic [1:0] OP_DEL = 2'd1;
    localparam logic [1:0] OP_SRC = 2'd2;
    localparam logic [1:0] OP_PRT = 2'd3;

    // ------------------------------------------------------------------
    // RX byte FIFO (pointers carry one extra wrap bit)
    // ------------------------------------------------------------------
    logic [7:0]  r_mem [FIFO_DEPTH];
    logic [AW:0] r_wptr;
    logic [AW:0] r_rptr;
    logic [AW:0] w_count;
    logic        w_empty;
    logic        w_full;
    logic [7:0]  w_head;
    logic        w_pop;
    logic        w_push;
    logic        w_echo_free;

    logic [2:0]        r_state;
    logic [1:0]        r_op;
    logic [DATA_W-1:0] r_acc;
    logic [CW-1:0]     r_cnt;
    logic              r_err;
    logic              r_ovf;

    assign w_count = r_wptr - r_rptr;
    assign w_empty = (r_wptr == r_rptr);
    assign w_full  = (w_count == DEPTH_C);
    assign w_head  = r_mem[r_rptr[AW-1:0]];

    // The parser owns the pop; it idles while a command is waiting in OUT.
    assign w_pop  = !w_empty && (r_state != S_OUT) && w_echo_free;
    // A full FIFO still takes the byte when the head leaves in the same cycle.
    assign w_push = i_rx_valid && (!w_full || w_pop);

    // FIFO storage write; contents need no reset because the pointers define validity
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr[AW-1:0]] <= i_rx_data;
        end
    end

    // FIFO pointer update
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PTR_ONE;
            end
        end
    end

    // Overflow pulse for a byte that found the FIFO full with no pop to make room
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovf <= 1'b0;
        end else begin
            r_ovf <= i_rx_valid && w_full && !w_pop;
        end
    end

    // ------------------------------------------------------------------
    // Byte classification of the FIFO head
    // ------------------------------------------------------------------
    logic       w_is_term;
    logic       w_is_space;
    logic       w_is_hex;
    logic [3:0] w_nibble;

    // Decode terminator / space / hex digit for the byte at the FIFO head
    always_comb begin
        w_is_term  = (w_head == 8'h0D) || (w_head == 8'h0A);
        w_is_space = (w_head == 8'h20);
        w_is_hex   = 1'b0;
        w_nibble   = '0;
        if (w_head >= "0" && w_head <= "9") begin
            w_is_hex = 1'b1;
            w_nibble = w_head[3:0];
        end else if ((w_head >= "A" && w_head <= "F") ||
                     (w_head >= "a" && w_head <= "f")) begin
            w_is_hex = 1'b1;
            w_nibble = w_head[3:0] + 4'd9;
        end
    end

    // ------------------------------------------------------------------
    // Line parser
    // ------------------------------------------------------------------
    // Parser state machine: consumes one popped byte per cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_op    <= '0;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_err   <= 1'b0;
        end else begin
            r_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        if (w_is_term || w_is_space) begin
                            r_state <= S_IDLE;
                        end else if (w_head == "I" || w_head == "D" || w_head == "S") begin
                            r_op    <= (w_head == "I") ? OP_INS :
                                       (w_head == "D") ? OP_DEL : OP_SRC;
                            r_acc   <= '0;
                            r_cnt   <= '0;
                            r_state <= S_ARG;
                        end else if (w_head == "P") begin
                            r_op    <= OP_PRT;
                            r_acc   <= '0;
                            r_cnt   <= '0;
                            r_state <= S_EOL;
                        end else begin
                            r_state <= S_ERR;
                        end
                    end
                end
                S_ARG: begin
                    if (w_pop) begin
                        if (w_is_space && r_cnt == '0) begin
                            r_state <= S_ARG;
                        end else if (w_is_hex) begin
                            if (r_cnt == MAXD_C) begin
                                r_state <= S_ERR;
                            end else begin
                                r_acc <= {r_acc[DATA_W-5:0], w_nibble};
                                r_cnt <= r_cnt + CNT_ONE;
                            end
                        end else if (w_is_term) begin
                            if (r_cnt != '0) begin
                                r_state <= S_OUT;
                            end else begin
                                r_err   <= 1'b1;
                                r_state <= S_IDLE;
                            end
                        end else if (w_is_space) begin
                            r_state <= S_EOL;
                        end else begin
                            r_state <= S_ERR;
                        end
                    end
                end
                S_EOL: begin
                    if (w_pop) begin
                        if (w_is_space) begin
                            r_state <= S_EOL;
                        end else if (w_is_term) begin
                            r_state <= S_OUT;
                        end else begin
                            r_state <= S_ERR;
                        end
                    end
                end
                S_OUT: begin
                    if (i_cmd_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                S_ERR: begin
                    if (w_pop && w_is_term) begin
                        r_err   <= 1'b1;
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_cmd_valid = (r_state == S_OUT);
    assign o_cmd_op    = r_op;
    assign o_cmd_data  = r_acc;
    assign o_err       = r_err;
    assign o_ovf       = r_ovf;

    // ------------------------------------------------------------------
    // Optional echo of consumed bytes
    // ------------------------------------------------------------------
`ifdef UART_CMD_RX_ECHO_EN
    logic       r_echo_valid;
    logic [7:0] r_echo_data;

    // A new byte may be popped only once the previous echo is taken (or in the same cycle)
    assign w_echo_free = !r_echo_valid || i_echo_ready;

    // Echo register: loads each popped byte, clears when accepted
    always_ff @(posedge clk) begin
        if (rst) begin
            r_echo_valid <= 1'b0;
            r_echo_data  <= '0;
        end else if (w_pop) begin
            r_echo_valid <= 1'b1;
            r_echo_data  <= w_head;
        end else if (i_echo_ready) begin
            r_echo_valid <= 1'b0;
        end
    end

    assign o_echo_valid = r_echo_valid;
    assign o_echo_data  = r_echo_data;
`else
    assign w_echo_free = 1'b1;
`endif

endmodule

// File: tb/tb_uart_cmd_rx.sv
// tb_uart_cmd_rx: scoreboard bench for uart_cmd_rx. Stimulus threads feed
// bytes and push expected events produced by a line-level reference parser;
// a monitor pops and compares on every command handshake and error pulse.
module tb_uart_cmd_rx;

    localparam int DATA_W     = 16;
    localparam int FIFO_DEPTH = 16;
    localparam int MAXD       = DATA_W / 4;
`ifdef UART_CMD_RX_ECHO_EN
    localparam int GMIN = 3;
    localparam int GMAX = 5;
`else
    localparam int GMIN = 1;
    localparam int GMAX = 3;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              i_rx_valid;
    logic [7:0]        i_rx_data;
    logic              o_cmd_valid;
    logic              i_cmd_ready;
    logic [1:0]        o_cmd_op;
    logic [DATA_W-1:0] o_cmd_data;
    logic              o_err;
    logic              o_ovf;
`ifdef UART_CMD_RX_ECHO_EN
    logic              o_echo_valid;
    logic [7:0]        o_echo_data;
    logic              i_echo_ready;
    byte unsigned      echo_q[$];
    int                echo_wait;
`endif

    always #5 clk = ~clk;

    uart_cmd_rx #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .i_rx_valid  (i_rx_valid),
        .i_rx_data   (i_rx_data),
        .o_cmd_valid (o_cmd_valid),
        .i_cmd_ready (i_cmd_ready),
        .o_cmd_op    (o_cmd_op),
        .o_cmd_data  (o_cmd_data),
        .o_err       (o_err),
        .o_ovf       (o_ovf)
`ifdef UART_CMD_RX_ECHO_EN
        ,
        .o_echo_valid(o_echo_valid),
        .o_echo_data (o_echo_data),
        .i_echo_ready(i_echo_ready)
`endif
    );

    typedef struct {
        int                kind;   // 1 = command, 2 = error pulse
        logic [1:0]        op;
        logic [DATA_W-1:0] data;
    } ev_t;

    ev_t          expq[$];
    byte unsigned line[$];
    int           total = 0;
    int           bad = 0;
    int           ovf_seen = 0;
    int           ovf_exp = 0;
    int           ready_mode = 0;  // 0 always ready, 1 random, 2 never

    // ---------------- reference model (whole-line parser) ----------------
    function automatic int hexval(input byte unsigned c);
        if (c >= "0" && c <= "9") return int'(c) - 48;
        if (c >= "A" && c <= "F") return int'(c) - 55;
        if (c >= "a" && c <= "f") return int'(c) - 87;
        return -1;
    endfunction

    function automatic bool_rest_blank(input int from);
        for (int k = from; k < line.size(); k++)
            if (line[k] != 8'h20) return 1'b0;
        return 1'b1;
    endfunction

    function automatic void push_ev(input int kind, input int op, input int data);
        ev_t e;
        e.kind = kind;
        e.op   = 2'(op);
        e.data = DATA_W'(data);
        expq.push_back(e);
    endfunction

    function automatic void eval_line();
        int i = 0;
        int n = line.size();
        int nd = 0;
        int val = 0;
        int op;
        byte unsigned c;
        while (i < n && line[i] == 8'h20) i++;
        if (i == n) return;
        c = line[i];
        i++;
        if (c == "P") begin
            if (bool_rest_blank(i)) push_ev(1, 3, 0);
            else push_ev(2, 0, 0);
        end else if (c == "I" || c == "D" || c == "S") begin
            op = (c == "I") ? 0 : (c == "D") ? 1 : 2;
            while (i < n && line[i] == 8'h20) i++;
            while (i < n && hexval(line[i]) >= 0) begin
                if (nd < 8) val = val * 16 + hexval(line[i]);
                nd++;
                i++;
            end
            if (nd >= 1 && nd <= MAXD && bool_rest_blank(i)) push_ev(1, op, val);
            else push_ev(2, 0, 0);
        end else begin
            push_ev(2, 0, 0);
        end
    endfunction

    function automatic void model_byte(input byte unsigned c);
        if (c == 8'h0D || c == 8'h0A) begin
            eval_line();
            line.delete();
        end else begin
            line.push_back(c);
        end
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input byte unsigned c, input bit accepted);
        i_rx_valid = 1'b1;
        i_rx_data  = c;
        if (accepted) begin
            model_byte(c);
`ifdef UART_CMD_RX_ECHO_EN
            echo_q.push_back(c);
`endif
        end
        cyc();
        i_rx_valid = 1'b0;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) begin
            send_byte(s[i], 1'b1);
            repeat ($urandom_range(GMAX, GMIN)) cyc();
        end
    endtask

    task automatic check(input string nm, input longint act, input longint req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0h, required %0h", nm, act, req);
        end
    endtask

    task automatic check_reset(input string nm);
        check({nm, "_valid"}, longint'(o_cmd_valid), 0);
        check({nm, "_err"},   longint'(o_err), 0);
        check({nm, "_ovf"},   longint'(o_ovf), 0);
        check({nm, "_op"},    longint'(o_cmd_op), 0);
        check({nm, "_data"},  longint'(o_cmd_data), 0);
    endtask

    task automatic wait_valid(input string nm);
        int k = 0;
        while (o_cmd_valid !== 1'b1 && k < 300) begin
            cyc();
            k++;
        end
        check(nm, longint'(o_cmd_valid === 1'b1), 1);
    endtask

    task automatic wait_drain(input string nm);
        int k = 0;
        while ((expq.size() != 0 || o_cmd_valid === 1'b1) && k < 3000) begin
            cyc();
            k++;
        end
        repeat (4) cyc();
        check(nm, longint'(expq.size()), 0);
    endtask

    // ---------------- consumer ready driver ----------------
    initial begin
        i_cmd_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       i_cmd_ready = 1'b1;
                1:       i_cmd_ready = ($urandom_range(3, 0) != 0);
                default: i_cmd_ready = 1'b0;
            endcase
        end
    end

`ifdef UART_CMD_RX_ECHO_EN
    // echo sink: holds ready low for a few cycles of each echoed byte
    initial begin
        i_echo_ready = 1'b0;
        echo_wait = 0;
        forever begin
            @(posedge clk);
            #1;
            if (i_echo_ready) begin
                i_echo_ready = 1'b0;
                echo_wait = 0;
            end else if (o_echo_valid) begin
                echo_wait++;
                i_echo_ready = (echo_wait >= 3);
            end
        end
    end
`endif

    // ---------------- monitor / scoreboard ----------------
    initial begin
        ev_t e;
        forever begin
            @(negedge clk);
            if (rst !== 1'b1) begin
                if (o_cmd_valid === 1'b1) begin
                    total++;
                    if (expq.size() == 0) begin
                        bad++;
                        $display("FAIL cmd_unexpected: got op=%0d data=%h, required no command",
                                 o_cmd_op, o_cmd_data);
                    end else begin
                        e = expq[0];
                        if (e.kind != 1 || o_cmd_op !== e.op || o_cmd_data !== e.data) begin
                            bad++;
                            $display("FAIL cmd: got op=%0d data=%h, required kind=%0d op=%0d data=%h",
                                     o_cmd_op, o_cmd_data, e.kind, e.op, e.data);
                        end
                        if (i_cmd_ready === 1'b1) e = expq.pop_front();
                    end
                end
                if (o_err === 1'b1) begin
                    total++;
                    if (expq.size() == 0) begin
                        bad++;
                        $display("FAIL err_unexpected: got o_err=1, required 0");
                    end else begin
                        e = expq.pop_front();
                        if (e.kind != 2) begin
                            bad++;
                            $display("FAIL err: got o_err=1, required command op=%0d data=%h",
                                     e.op, e.data);
                        end
                    end
                end
                if (o_ovf === 1'b1) ovf_seen++;
`ifdef UART_CMD_RX_ECHO_EN
                if (o_echo_valid === 1'b1 && i_echo_ready === 1'b1) begin
                    total++;
                    if (echo_q.size() == 0) begin
                        bad++;
                        $display("FAIL echo_unexpected: got %h, required none", o_echo_data);
                    end else if (o_echo_data !== echo_q[0]) begin
                        bad++;
                        $display("FAIL echo: got %h, required %h", o_echo_data, echo_q[0]);
                        void'(echo_q.pop_front());
                    end else begin
                        void'(echo_q.pop_front());
                    end
                end
`endif
            end
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1);
    end

    // ---------------- main sequence ----------------
    initial begin
        string        ovf_s;
        string        hexs;
        string        ops;
        byte unsigned lq[$];
        int           kind;
        int           nd;

        rst        = 1'b1;
        i_rx_valid = 1'b0;
        i_rx_data  = '0;
        ready_mode = 0;
        repeat (3) @(posedge clk);
        #1;
        check_reset("reset");
        rst = 1'b0;
        cyc();

        // basic insert
        send_str("I1A2F\r");
        wait_drain("drain_insert");

        // held command under back-pressure, then print
        ready_mode = 2;
        send_str("D 00ff\n");
        wait_valid("delete_valid");
        for (int i = 0; i < 5; i++) begin
            check("delete_hold", longint'(o_cmd_valid), 1);
            cyc();
        end
        ready_mode = 0;
        send_str("P\r");
        wait_drain("drain_print");

        // too many digits, then a good search; malformed lines
        send_str("S12345\rS7\r");
        send_str("Q12\rI\rP5\r");
        wait_drain("drain_errors");

        // overflow: park the parser in OUT, then stream 20 bytes back to back
        ready_mode = 2;
        send_str("P\r");
        wait_valid("ovf_park");
        ovf_s = "I11\rD22\rS33\rI44\rD55\r";
        for (int i = 0; i < 20; i++) send_byte(ovf_s[i], i < FIFO_DEPTH);
        ovf_exp += 20 - FIFO_DEPTH;
        repeat (4) cyc();
        ready_mode = 0;
        wait_drain("drain_overflow");
        check("ovf_count", longint'(ovf_seen), longint'(ovf_exp));

        // reset in the middle of a line
        send_str("I12");
        repeat (30) cyc();
        rst = 1'b1;
        cyc();
        check_reset("midline_reset");
        line.delete();
`ifdef UART_CMD_RX_ECHO_EN
        echo_q.delete();
`endif
        rst = 1'b0;
        cyc();
        send_str("I3\r");
        wait_drain("drain_after_reset");

        // randomized lines with random consumer back-pressure
        hexs = "0123456789abcdefABCDEF";
        ops  = "IDSP";
        ready_mode = 1;
        for (int l = 0; l < 40; l++) begin
            lq.delete();
            kind = $urandom_range(9, 0);
            repeat ($urandom_range(1, 0)) lq.push_back(8'h20);
            if (kind <= 5) begin
                lq.push_back(ops[$urandom_range(3, 0)]);
                if (lq[lq.size()-1] != "P") begin
                    repeat ($urandom_range(2, 0)) lq.push_back(8'h20);
                    nd = ($urandom_range(9, 0) == 0) ? MAXD + 1 : $urandom_range(MAXD, 1);
                    repeat (nd) lq.push_back(hexs[$urandom_range(21, 0)]);
                end
                repeat ($urandom_range(2, 0)) lq.push_back(8'h20);
            end else if (kind <= 7) begin
                repeat ($urandom_range(4, 1)) lq.push_back(8'($urandom_range(126, 33)));
            end else if (kind == 9) begin
                lq.push_back(ops[$urandom_range(2, 0)]);
                lq.push_back(8'h20);
            end
            lq.push_back(($urandom_range(1, 0) == 0) ? 8'h0D : 8'h0A);
            foreach (lq[i]) begin
                send_byte(lq[i], 1'b1);
                repeat ($urandom_range(GMAX, GMIN)) cyc();
            end
        end
        ready_mode = 0;
        wait_drain("drain_random");
        check("ovf_final", longint'(ovf_seen), longint'(ovf_exp));
`ifdef UART_CMD_RX_ECHO_EN
        repeat (20) cyc();
        check("echo_drain", longint'(echo_q.size()), 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
